// File: rtl/fifo_rd_pkg.sv
// Shared constants and types for the FIFO read adapter slice.
// BUF_DEPTH sets the output buffer size; the occupancy counter (OCC_W bits)
// spans 0..BUF_DEPTH. ptr_inc advances a circular buffer index.
package fifo_rd_pkg;

  localparam int BUF_DEPTH  = 3;
  localparam int OCC_W      = 2;
  localparam int DEF_DATA_W = 8;

  typedef logic [OCC_W-1:0] occ_t;
  typedef logic [1:0]       ptr_t;

  // Circular increment over 0..BUF_DEPTH-1
  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(BUF_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_adapter_if.sv
// Bus bundle for fifo_rd_adapter: FIFO read side plus output stream side.
// Handshake rules:
//   FIFO side  : fifo_rd_en is a pop request, issued only while fifo_empty=0;
//                fifo_dout carries the popped word one cycle later.
//   Stream side: a word transfers on every clk edge with m_valid && m_ready;
//                while m_valid && !m_ready, m_data and m_last hold steady.
// master = the adapter, slave = the FIFO/sink environment.
interface fifo_rd_adapter_if #(
  parameter int DATA_W = fifo_rd_pkg::DEF_DATA_W
);
  logic              fifo_empty;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_dout;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (
    input  fifo_empty, fifo_dout, m_ready,
    output fifo_rd_en, m_data, m_valid, m_last
  );

  modport slave (
    output fifo_empty, fifo_dout, m_ready,
    input  fifo_rd_en, m_data, m_valid, m_last
  );
endinterface

// File: rtl/fifo_rd_skidbuf.sv
// Three-entry in-order buffer (circular, read/write pointers plus an
// occupancy count). The head entry is exposed on dout_o; dout_o reads 0
// while empty. A push into a full buffer or a pop from an empty one is ignored.
module fifo_rd_skidbuf
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output occ_t              occ_o
);

  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  ptr_t              rd_ptr_q;
  ptr_t              wr_ptr_q;
  occ_t              occ_q;
  occ_t              occ_d;
  logic              push_ok;
  logic              pop_ok;

  assign pop_ok  = pop_i && (occ_q != '0);
  assign push_ok = push_i && (occ_q != occ_t'(BUF_DEPTH));

  // Next occupancy: simultaneous push and pop leave it unchanged
  always_comb begin
    occ_d = occ_q;
    case ({push_ok, pop_ok})
      2'b10:   occ_d = occ_q + occ_t'(1);
      2'b01:   occ_d = occ_q - occ_t'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Storage, pointers and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BUF_DEPTH; i++) mem_q[i] <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din_i;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop_ok) rd_ptr_q <= ptr_inc(rd_ptr_q);
      occ_q <= occ_d;
    end
  end

  assign dout_o = (occ_q != '0) ? mem_q[rd_ptr_q] : '0;
  assign occ_o  = occ_q;

endmodule

// File: rtl/fifo_rd_adapter.sv
// Drains a registered-output FIFO into a valid/ready stream.
// Pops are issued whenever the buffer can absorb every word already in
// flight (occ + pend < 3), so the pop request never looks at m_ready and the
// stream still sustains one word per cycle. A beat counter marks the last
// word of each PKT_LEN-word packet on m_last.
// Optional build macro FIFO_RD_STATS_EN adds xfer_cnt (wrapping transfer
// count) and stall_cnt (saturating count of m_valid && !m_ready cycles).
module fifo_rd_adapter
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int PKT_LEN = 4
) (
  input  logic               clk,
  input  logic               rst,
  fifo_rd_adapter_if.master  bus
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [15:0]        xfer_cnt,
  output logic [15:0]        stall_cnt
`endif
);

  localparam int BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  occ_t              occ;
  logic              pend_q;
  logic              rd_en;
  logic              xfer;
  logic [DATA_W-1:0] head_data;
  logic [BEAT_W-1:0] beat_q;
  logic [BEAT_W-1:0] beat_d;
  logic              beat_end;

  fifo_rd_skidbuf #(
    .DATA_W (DATA_W)
  ) u_buf (
    .clk    (clk),
    .rst    (rst),
    .push_i (pend_q),
    .pop_i  (xfer),
    .din_i  (bus.fifo_dout),
    .dout_o (head_data),
    .occ_o  (occ)
  );

  // Pop request: room for this word plus the one still in flight
  always_comb begin
    rd_en = !rst && !bus.fifo_empty &&
            (({1'b0, occ} + {2'b00, pend_q}) < 3'd3);
  end

  // In-flight flag: the FIFO returns data the cycle after a pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pend_q <= 1'b0;
    else     pend_q <= rd_en;
  end

  assign xfer     = bus.m_valid && bus.m_ready;
  assign beat_end = (beat_q == BEAT_W'(PKT_LEN - 1));

  // Next beat: advance per transfer, wrap at the packet end
  always_comb begin
    beat_d = beat_q;
    if (xfer) beat_d = beat_end ? '0 : beat_q + BEAT_W'(1);
  end

  // Beat counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) beat_q <= '0;
    else     beat_q <= beat_d;
  end

  assign bus.fifo_rd_en = rd_en;
  assign bus.m_valid    = (occ != '0);
  assign bus.m_data     = head_data;
  assign bus.m_last     = beat_end && bus.m_valid;

`ifdef FIFO_RD_STATS_EN
  logic [15:0] xfer_cnt_q;
  logic [15:0] stall_cnt_q;

  // Transfer count wraps; stall count sticks at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xfer_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (xfer) xfer_cnt_q <= xfer_cnt_q + 16'd1;
      if (bus.m_valid && !bus.m_ready && (stall_cnt_q != 16'hFFFF))
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign xfer_cnt  = xfer_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_adapter.sv
// Bench for fifo_rd_adapter: behavioural registered-output FIFO, scoreboard
// queue of expected stream words, beat model for m_last. A second instance
// with PKT_LEN=1 shares the same inputs and must flag every valid word last.
module tb_fifo_rd_adapter;

  localparam int DATA_W  = 8;
  localparam int PKT_LEN = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fifo_rd_adapter_if #(.DATA_W(DATA_W)) bus  ();
  fifo_rd_adapter_if #(.DATA_W(DATA_W)) bus1 ();

  assign bus1.fifo_empty = bus.fifo_empty;
  assign bus1.fifo_dout  = bus.fifo_dout;
  assign bus1.m_ready    = bus.m_ready;

`ifdef FIFO_RD_STATS_EN
  logic [15:0] xfer_cnt, stall_cnt, xfer_cnt1, stall_cnt1;
`endif

  fifo_rd_adapter #(.DATA_W(DATA_W), .PKT_LEN(PKT_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FIFO_RD_STATS_EN
    ,
    .xfer_cnt  (xfer_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  fifo_rd_adapter #(.DATA_W(DATA_W), .PKT_LEN(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
`ifdef FIFO_RD_STATS_EN
    ,
    .xfer_cnt  (xfer_cnt1),
    .stall_cnt (stall_cnt1)
`endif
  );

  logic [DATA_W-1:0] src_q[$];
  logic [DATA_W-1:0] exp_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_beat, xfers, pops, lasts, cyc;
  bit rand_ready, ready_level, stall_prev, last_valid;
  logic [DATA_W-1:0] held;
  bit rd_log[8];
  bit valid_log[8];

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic push_word(input logic [DATA_W-1:0] w);
    src_q.push_back(w);
    exp_q.push_back(w);
    bus.fifo_empty = 1'b0;
  endtask

  task automatic clear_model();
    src_q.delete();
    exp_q.delete();
    bus.fifo_empty = 1'b1;
    bus.fifo_dout  = '0;
    exp_beat   = 0;
    stall_prev = 0;
    last_valid = 0;
  endtask

  // One clock: monitor at negedge, then FIFO model and ready update after posedge
  task automatic step();
    logic rd_seen;
    @(negedge clk);
    rd_seen = bus.fifo_rd_en;
    check_val("no_pop_empty", 32'(bus.fifo_rd_en & bus.fifo_empty), 0);
    check_val("m_last", 32'(bus.m_last), 32'(bus.m_valid && (exp_beat == PKT_LEN - 1)));
    check_val("last_pkt1", 32'(bus1.m_last), 32'(bus1.m_valid));
    if (stall_prev) begin
      check_val("hold_valid", 32'(bus.m_valid), 1);
      check_val("hold_data", 32'(bus.m_data), 32'(held));
    end
    stall_prev = bus.m_valid && !bus.m_ready;
    held       = bus.m_data;
    if (bus.m_valid && bus.m_ready) begin
      xfers++;
      if (bus.m_last) lasts++;
      if (exp_q.size() == 0) check_val("spurious_xfer", 32'(bus.m_data), 32'hFFFF_FFFF);
      else check_val("data", 32'(bus.m_data), 32'(exp_q.pop_front()));
      exp_beat = (exp_beat == PKT_LEN - 1) ? 0 : exp_beat + 1;
    end
    if (rd_seen) pops++;
    last_valid = bus.m_valid;
    if (cyc < 8) begin
      rd_log[cyc]    = rd_seen;
      valid_log[cyc] = bus.m_valid;
    end
    cyc++;
    @(posedge clk);
    #1;
    if (rd_seen && src_q.size() > 0) bus.fifo_dout = src_q.pop_front();
    bus.fifo_empty = (src_q.size() == 0);
    bus.m_ready    = rand_ready ? 1'($urandom_range(0, 1)) : ready_level;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_model();
    bus.m_ready = 1'b0;
    ready_level = 0;
    rand_ready  = 0;
    repeat (2) @(negedge clk);
    check_val("rst_valid", 32'(bus.m_valid), 0);
    check_val("rst_last", 32'(bus.m_last), 0);
    check_val("rst_data", 32'(bus.m_data), 0);
    check_val("rst_rd_en", 32'(bus.fifo_rd_en), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc = 0; pops = 0; xfers = 0; lasts = 0;
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      step();
      n++;
    end
    check_val("drain_done", 32'(exp_q.size()), 0);
    repeat (3) step();
  endtask

  initial begin
    int n, sent;
    bus.fifo_empty = 1'b1;
    bus.fifo_dout  = '0;
    bus.m_ready    = 1'b0;

    // Three preloaded words, ready held high: latency and back-to-back flow
    do_reset();
    ready_level = 1; bus.m_ready = 1'b1;
    push_word(8'h11); push_word(8'h22); push_word(8'h33);
    repeat (6) step();
    for (int i = 0; i < 3; i++) check_val($sformatf("rd_en_c%0d", i), 32'(rd_log[i]), 1);
    check_val("rd_en_c3", 32'(rd_log[3]), 0);
    for (int i = 0; i < 2; i++) check_val($sformatf("valid_c%0d", i), 32'(valid_log[i]), 0);
    for (int i = 2; i < 5; i++) check_val($sformatf("valid_c%0d", i), 32'(valid_log[i]), 1);
    check_val("valid_c5", 32'(valid_log[5]), 0);
    check_val("xfers_3", 32'(xfers), 3);
    check_val("lasts_3", 32'(lasts), 0);

    // Eight words against a stalled sink: three pops fill the buffer, then drain
    do_reset();
    for (int i = 0; i < 8; i++) push_word(8'(8'h40 + i));
    repeat (10) step();
    check_val("stall_pops", 32'(pops), 3);
    check_val("stall_occ", 32'(dut.occ), 3);
    check_val("stall_rd_en", 32'(bus.fifo_rd_en), 0);
    ready_level = 1; bus.m_ready = 1'b1;
    drain(100);
    check_val("xfers_8", 32'(xfers), 8);
    check_val("lasts_8", 32'(lasts), 2);
    check_val("pops_8", 32'(pops), 8);

    // Reset with two buffered words and one in flight
    do_reset();
    for (int i = 0; i < 6; i++) push_word(8'(8'h60 + i));
    repeat (3) step();
    check_val("pre_occ", 32'(dut.occ), 2);
    check_val("pre_pend", 32'(dut.pend_q), 1);
    rst = 1'b1;
    clear_model();
    @(negedge clk);
    check_val("mid_rst_valid", 32'(bus.m_valid), 0);
    check_val("mid_rst_rd_en", 32'(bus.fifo_rd_en), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    xfers = 0;
    push_word(8'hA5); push_word(8'h5A);
    ready_level = 1; bus.m_ready = 1'b1;
    drain(50);
    check_val("post_rst_xfers", 32'(xfers), 2);

    // Ten words with exactly five stall cycles
    do_reset();
    for (int i = 0; i < 10; i++) push_word(8'(8'h80 + i));
    n = 0;
    do begin
      step();
      n++;
    end while (!last_valid && n < 20);
    check_val("stat_valid_seen", 32'(last_valid), 1);
    repeat (3) step();
    ready_level = 1;
    step();
    drain(100);
    check_val("stat_xfers", 32'(xfers), 10);
`ifdef FIFO_RD_STATS_EN
    check_val("xfer_cnt", 32'(xfer_cnt), 10);
    check_val("stall_cnt", 32'(stall_cnt), 5);
`endif

    // 1000 random words, random ready, bursty FIFO fill
    do_reset();
    rand_ready  = 1;
    bus.m_ready = 1'($urandom_range(0, 1));
    sent = 0;
    n    = 0;
    while ((sent < 1000 || exp_q.size() != 0) && n < 20000) begin
      if (sent < 1000 && src_q.size() < 6 && $urandom_range(0, 3) != 0) begin
        push_word(DATA_W'($urandom_range(0, 255)));
        sent++;
      end
      step();
      n++;
    end
    check_val("rand_left", 32'(exp_q.size()), 0);
    check_val("rand_xfers", 32'(xfers), 1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_adapter.md
FIFO_RD_ADAPTER -- requirements
Module: fifo_rd_adapter

Interface
REQ-001 The block SHALL use reset rst, asynchronous, active-high; clock clk.
REQ-002 The block SHALL have parameter DATA_W, default 8, setting the data word width.
REQ-003 The block SHALL have parameter PKT_LEN, default 4, setting the words per packet for m_last; legal range 1..256.
REQ-004 The block SHALL have port clk  in  1  system clock.
REQ-005 The block SHALL have port rst  in  1  async active-high reset.
REQ-006 The block SHALL have port fifo_empty  in  1  FIFO empty flag.
REQ-007 The block SHALL have port fifo_rd_en  out  1  FIFO pop request.
REQ-008 The block SHALL have port fifo_dout  in  DATA_W  FIFO registered read data, valid one cycle after an accepted pop.
REQ-009 The block SHALL have port m_data  out  DATA_W  stream output data.
REQ-010 The block SHALL have port m_valid  out  1  stream data valid.
REQ-011 The block SHALL have port m_ready  in  1  downstream ready.
REQ-012 The block SHALL have port m_last  out  1  last word of packet.

Function
REQ-013 The block SHALL drain the FIFO into a 3-entry in-order output buffer and present the head entry on m_data/m_valid/m_last.
REQ-014 The block SHALL drive fifo_rd_en = !fifo_empty && (occ + pend) < 3, where occ is buffer occupancy (0..3) and pend is fifo_rd_en registered from the previous cycle; fifo_rd_en SHALL NOT depend combinationally on m_ready.
REQ-015 The block SHALL capture fifo_dout into the buffer at the clock edge ending every cycle in which pend=1.
REQ-016 A transfer SHALL occur on every edge with m_valid && m_ready; it SHALL pop the head entry, and m_data SHALL hold stable while m_valid && !m_ready.
REQ-017 Latency SHALL be 2 cycles from fifo_rd_en high to m_valid high for an empty buffer.
REQ-018 Sustained throughput SHALL be one word per cycle while the FIFO is non-empty and m_ready=1.
REQ-019 Simultaneous capture and transfer in one cycle SHALL leave occ unchanged; occ SHALL never exceed 3 or underflow.
REQ-020 A beat counter (0..PKT_LEN-1) SHALL increment per transfer and wrap to 0; m_last SHALL equal (beat == PKT_LEN-1) && m_valid.
REQ-021 With PKT_LEN=1, m_last SHALL be high on every valid word.

Reset
REQ-022 On rst, occ, pend and beat SHALL clear; m_valid=0, m_last=0, m_data=0; fifo_rd_en SHALL be 0 while rst is high.
REQ-023 Reset mid-operation SHALL discard buffered and in-flight words; rst is shared with the FIFO so both sides restart empty.

Configuration
REQ-024 When macro FIFO_RD_STATS_EN is defined, the block SHALL add outputs xfer_cnt[15:0] (transfers, wrapping) and stall_cnt[15:0] (cycles with m_valid && !m_ready, saturating at 16'hFFFF), both reset to 0.
REQ-025 When FIFO_RD_STATS_EN is undefined, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-026 Package fifo_rd_pkg SHALL hold BUF_DEPTH=3, the occupancy width (2 bits) and the default DATA_W.
REQ-027 The 3-entry buffer SHALL be sub-module fifo_rd_skidbuf (push, pop, data in/out, occ); the pop-request logic, beat counter and stats SHALL live in fifo_rd_adapter.

Verification
REQ-028 FIFO preloaded 0x11,0x22,0x33, m_ready=1 -> fifo_rd_en cycles 0-2, m_valid cycles 2-4 with data 0x11,0x22,0x33, m_last=0.
REQ-029 Preload 8 words, m_ready=0 -> exactly 3 pops, occ=3, fifo_rd_en stays 0; raise m_ready -> 8 words in order, no duplicates or gaps.
REQ-030 PKT_LEN=4, 8 words streamed -> m_last high on 4th and 8th transfers only.
REQ-031 Random m_ready (50%) over 1000 words -> output sequence equals input, occ<=3, no pop while fifo_empty=1.
REQ-032 rst asserted with occ=2 and pend=1 -> next cycle m_valid=0, fifo_rd_en=0; after release new data 0xA5 emerges first.
REQ-033 FIFO_RD_STATS_EN defined, 10 transfers and 5 stall cycles -> xfer_cnt=10, stall_cnt=5.
